serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and sum width in bits, with legal range 1..64.
REQ-002 The block SHALL have input clk, 1 bit, its single clock; all state SHALL change on the rising edge of clk only.
REQ-003 The block SHALL have input rst, 1 bit, an active-high reset that is synchronous to clk.
REQ-004 The block SHALL have input start, 1 bit, a request to begin an operation.
REQ-005 The block SHALL have input a, WIDTH bits, the first operand.
REQ-006 The block SHALL have input b, WIDTH bits, the second operand.
REQ-007 The block SHALL have input cin, 1 bit, the carry-in used in add mode.
REQ-008 The block SHALL have input sub, 1 bit, the mode select: 0 = a+b+cin, 1 = a-b.
REQ-009 The block SHALL have output busy, 1 bit, high while bits are being processed.
REQ-010 The block SHALL have output done, 1 bit, a single-cycle pulse indicating that the result is valid.
REQ-011 The block SHALL have output sum, WIDTH bits, the result.
REQ-012 The block SHALL have output cout, 1 bit, the final carry; in sub mode 1 means no borrow.

Function
REQ-013 The block SHALL implement a three-state FSM with states IDLE, BUSY and DONE.
REQ-014 In IDLE, start=1 at an edge SHALL be accepted: a, b, cin and sub are latched, the bit counter is cleared, and the state becomes BUSY.
REQ-015 In BUSY, each edge SHALL process exactly one bit, LSB first, using the one-bit full-adder relations s = x^y^c and c' = x&y | c&(x^y).
REQ-016 The block SHALL compute in sub mode with y = ~b[i] and initial carry 1, ignoring cin; in add mode it SHALL use y = b[i] and initial carry = latched cin.
REQ-017 The FSM SHALL move BUSY -> DONE on the edge that processes bit WIDTH-1, so the operation takes exactly WIDTH edges in BUSY.
REQ-018 Latency: if start is accepted at edge k, done SHALL be high in the cycle following edge k+WIDTH, and for that one cycle only.
REQ-019 The FSM SHALL move DONE -> IDLE unconditionally on the next edge.
REQ-020 busy SHALL be 1 in BUSY and 0 in IDLE and DONE.
REQ-021 start SHALL be ignored in BUSY and DONE; latched operands and mode SHALL remain unaffected by input changes after acceptance.
REQ-022 sum and cout SHALL equal the (WIDTH+1)-bit result {cout,sum} = a + (sub ? ~b + 1 : b + cin), truncated to WIDTH+1 bits.
REQ-023 sum and cout SHALL be valid from the DONE cycle and held stable until the next accepted start.
REQ-024 Contents of sum and cout during BUSY are unspecified and SHALL NOT be relied on.
REQ-025 When WIDTH=1 the block SHALL still spend exactly one cycle in BUSY.

Reset
REQ-026 While rst=1 at an edge, the state SHALL become IDLE, with busy=0, done=0, sum=0, cout=0, the counter cleared, and latched operands cleared.
REQ-027 rst SHALL take priority over start and over any in-progress operation; a reset in BUSY or DONE SHALL abort the operation without producing a done pulse.
REQ-028 start asserted in the same cycle as rst SHALL NOT be accepted.

Verification
REQ-029 WIDTH=8, add: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, busy high for exactly 8 cycles, done a single pulse 8 edges after acceptance.
REQ-030 WIDTH=8, add with carry-in: a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0.
REQ-031 WIDTH=8, sub: a=0x05, b=0x07 (cin=1, ignored) -> sum=0xFE, cout=0; and a=0x07, b=0x05 -> sum=0x02, cout=1.
REQ-032 WIDTH=8: start=1 with a=0x10, b=0x20; re-assert start with a=0xAA, b=0x55 during BUSY and DONE -> sum=0x30 and only one done pulse.
REQ-033 WIDTH=8: assert rst at the 4th BUSY cycle -> next cycle busy=0, done=0, sum=0x00, cout=0, no done pulse; a fresh start after that completes correctly.
REQ-034 WIDTH=1: drive all 8 combinations of a, b, cin in add mode -> {cout,sum} equals a+b+cin for each, with done one edge after each acceptance.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder/subtractor.
// An accepted request is processed one bit per clock, LSB first, through a
// single full-adder cell. The result stays in sum/cout until the next
// request is accepted.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter wide enough to hold WIDTH-1 for every WIDTH >= 1.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam int TOP_SHIFT = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_q;      // operand a, shifted right once per processed bit
    logic [WIDTH-1:0] b_q;      // operand b, shifted right once per processed bit
    logic             sub_q;    // latched mode
    logic             carry_q;  // running carry between bit slices
    logic [WIDTH-1:0] sum_q;    // result, filled from the MSB end as bits shift in
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic             x_bit;
    logic             y_bit;
    logic             s_bit;
    logic             carry_d;
    logic [WIDTH-1:0] sum_d;

    // One full-adder slice on the current LSBs; subtraction inverts b.
    always_comb begin
        x_bit   = a_q[0];
        y_bit   = b_q[0] ^ sub_q;
        s_bit   = x_bit ^ y_bit ^ carry_q;
        carry_d = (x_bit & y_bit) | (carry_q & (x_bit ^ y_bit));
        // New bit enters at the top; after WIDTH shifts bit 0 lands at sum[0].
        sum_d   = (sum_q >> 1) | (WIDTH'(s_bit) << TOP_SHIFT);
    end

    // Control FSM and datapath registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        sub_q   <= sub;
                        // Subtraction is a + ~b + 1, so carry seeds at 1.
                        carry_q <= sub ? 1'b1 : cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    sum_q   <= sum_d;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        cout_q  <= carry_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // start is deliberately ignored here.
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: WIDTH=8 and WIDTH=1 instances, directed and
// random operations checked against an arithmetic reference model.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;
    logic       sub8 = 1'b0;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       cin1 = 1'b0;
    logic       sub1 = 1'b0;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .sub(sub8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .sub(sub1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    // Reference: (W+1)-bit result of a + (sub ? -b : b + cin).
    function automatic int model(input int w, input int a, input int b,
                                 input int cin, input int sub);
        int mask;
        int full;
        mask = (1 << w) - 1;
        full = (1 << (w + 1)) - 1;
        if (sub != 0) return (a + ((~b) & mask) + 1) & full;
        return (a + b + cin) & full;
    endfunction

    // Full 8-bit operation: drives a request, checks busy/done timing and result.
    task automatic run_op8(input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic sub, input string name);
        int exp;
        exp = model(8, int'(a), int'(b), int'(cin), int'(sub));
        a8 = a; b8 = b; cin8 = cin; sub8 = sub; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        // Scramble inputs to show latched values are used.
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = ~cin; sub8 = ~sub;
        n_vec++;
        if (busy8 !== 1'b1 || done8 !== 1'b0) begin
            n_err++;
            $display("FAIL %s accept: busy=%b done=%b required busy=1 done=0", name, busy8, done8);
        end
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if (i < 8) begin
                if (busy8 !== 1'b1 || done8 !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s cycle %0d: busy=%b done=%b required busy=1 done=0", name, i, busy8, done8);
                end
            end else begin
                if (busy8 !== 1'b0 || done8 !== 1'b1 || {cout8, sum8} !== 9'(exp)) begin
                    n_err++;
                    $display("FAIL %s done: busy=%b done=%b cout,sum=%h required busy=0 done=1 cout,sum=%h",
                             name, busy8, done8, {cout8, sum8}, 9'(exp));
                end
            end
        end
        @(posedge clk); #1;
        n_vec++;
        if (done8 !== 1'b0 || busy8 !== 1'b0 || {cout8, sum8} !== 9'(exp)) begin
            n_err++;
            $display("FAIL %s hold: busy=%b done=%b cout,sum=%h required busy=0 done=0 cout,sum=%h",
                     name, busy8, done8, {cout8, sum8}, 9'(exp));
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
            n_err++;
            $display("FAIL reset8: busy=%b done=%b sum=%h cout=%b required all zero", busy8, done8, sum8, cout8);
        end
        n_vec++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || sum1 !== 1'b0 || cout1 !== 1'b0) begin
            n_err++;
            $display("FAIL reset1: busy=%b done=%b sum=%b cout=%b required all zero", busy1, done1, sum1, cout1);
        end
        // start was high during reset and must not have been accepted.
        start8 = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (busy8 !== 1'b0) begin
            n_err++;
            $display("FAIL start_in_reset: busy=%b required 0", busy8);
        end
    endtask

    task automatic test_directed;
        run_op8(8'hFF, 8'h01, 1'b0, 1'b0, "add_ff_01");
        run_op8(8'h7F, 8'h00, 1'b1, 1'b0, "add_cin");
        run_op8(8'h05, 8'h07, 1'b1, 1'b1, "sub_5_7");
        run_op8(8'h07, 8'h05, 1'b0, 1'b1, "sub_7_5");
        run_op8(8'h00, 8'h00, 1'b0, 1'b1, "sub_0_0");
        run_op8(8'hFF, 8'hFF, 1'b1, 1'b0, "add_max");
    endtask

    task automatic test_ignore_start;
        int pulses;
        pulses = 0;
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        a8 = 8'hAA; b8 = 8'h55;
        // start stays high through BUSY (8 cycles) and the DONE cycle.
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1;
            if (done8 === 1'b1) pulses++;
        end
        start8 = 1'b0;
        n_vec++;
        if (sum8 !== 8'h30 || cout8 !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_start result: cout=%b sum=%h required cout=0 sum=30", cout8, sum8);
        end
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done8 === 1'b1) pulses++;
        end
        n_vec++;
        if (pulses != 1 || busy8 !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_start pulses: pulses=%0d busy=%b required pulses=1 busy=0", pulses, busy8);
        end
    endtask

    task automatic test_abort;
        int pulses;
        pulses = 0;
        a8 = 8'h3C; b8 = 8'h0F; cin8 = 1'b1; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;   // during the 4th BUSY cycle
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
            n_err++;
            $display("FAIL abort: busy=%b done=%b sum=%h cout=%b required all zero", busy8, done8, sum8, cout8);
        end
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done8 === 1'b1 || busy8 === 1'b1) pulses++;
        end
        n_vec++;
        if (pulses != 0) begin
            n_err++;
            $display("FAIL abort quiet: active cycles=%0d required 0", pulses);
        end
        run_op8(8'h3C, 8'h0F, 1'b1, 1'b0, "after_abort");
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            run_op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), "random");
        end
    endtask

    task automatic test_width1;
        int exp;
        for (int v = 0; v < 8; v++) begin
            exp = model(1, v & 1, (v >> 1) & 1, (v >> 2) & 1, 0);
            a1 = 1'(v); b1 = 1'(v >> 1); cin1 = 1'(v >> 2); sub1 = 1'b0; start1 = 1'b1;
            @(posedge clk); #1;
            start1 = 1'b0;
            n_vec++;
            if (busy1 !== 1'b1 || done1 !== 1'b0) begin
                n_err++;
                $display("FAIL w1 accept v=%0d: busy=%b done=%b required busy=1 done=0", v, busy1, done1);
            end
            @(posedge clk); #1;
            n_vec++;
            if (done1 !== 1'b1 || busy1 !== 1'b0 || {cout1, sum1} !== 2'(exp)) begin
                n_err++;
                $display("FAIL w1 done v=%0d: busy=%b done=%b cout,sum=%b required busy=0 done=1 cout,sum=%b",
                         v, busy1, done1, {cout1, sum1}, 2'(exp));
            end
            @(posedge clk); #1;
            n_vec++;
            if (done1 !== 1'b0) begin
                n_err++;
                $display("FAIL w1 pulse v=%0d: done=%b required 0", v, done1);
            end
        end
        // A subtraction on the 1-bit instance as well.
        a1 = 1'b0; b1 = 1'b1; sub1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (done1 !== 1'b1 || {cout1, sum1} !== 2'(model(1, 0, 1, 1, 1))) begin
            n_err++;
            $display("FAIL w1 sub: done=%b cout,sum=%b required done=1 cout,sum=%b",
                     done1, {cout1, sum1}, 2'(model(1, 0, 1, 1, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_abort();
        test_random();
        test_width1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
